// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - programmable up/down counter with prescaler, wrap/saturate/one-shot modes
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  direction,
  input  logic [WIDTH-1:0]      max_value,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            mode,
  output logic [WIDTH-1:0]      count,
  output logic                  tc_pulse,
  output logic                  active
);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;
  logic                  at_term;
  logic                  stuck_at_term;
  logic [WIDTH-1:0]      term_val;
  logic [WIDTH-1:0]      next_count;
  logic                  next_active;
  logic                  next_tc;

  always_comb begin
    // >= rather than == so a prescale shrunk below pcnt recovers on the next enabled cycle
    tick          = enable & active & ~load & (pcnt >= prescale);
    at_term       = direction ? (count >= max_value) : (count == '0);
    term_val      = direction ? max_value : '0;
    stuck_at_term = ((mode == MODE_SAT) || (mode == MODE_ONESHOT)) && (count == term_val);
    next_count    = count;
    next_active   = active;
    if (!at_term) begin
      next_count = direction ? count + 1'b1 : count - 1'b1;
    end else begin
      case (mode)
        MODE_SAT:     next_count  = term_val;
        MODE_ONESHOT: next_active = 1'b0;
        default:      next_count  = direction ? '0 : max_value;
      endcase
    end
    next_tc = (next_count == term_val) && !stuck_at_term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      pcnt     <= '0;
      tc_pulse <= 1'b0;
      active   <= 1'b1;
    end else if (load) begin
      count    <= load_value;
      pcnt     <= '0;
      tc_pulse <= 1'b0;
      active   <= 1'b1;
    end else if (tick) begin
      count    <= next_count;
      pcnt     <= '0;
      tc_pulse <= next_tc;
      active   <= next_active;
    end else begin
      tc_pulse <= 1'b0;
      if (enable && active) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - vector table, directed corner sequences and randomized model check of prog_counter
module tb_prog_counter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic       direction;
  logic [7:0] max_value;
  logic [7:0] prescale;
  logic [1:0] mode;
  logic [7:0] count;
  logic       tc_pulse;
  logic       active;

  int checks = 0;
  int errors = 0;

  int m_count, m_pcnt, m_active, m_tc;

  typedef struct {
    bit ld; int lv; bit en; bit dir; int mx; int ps; int md;
    int ec; bit et; bit ea;
  } vec_t;
  vec_t vecs[$];

  prog_counter #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
    .direction(direction), .max_value(max_value), .prescale(prescale), .mode(mode),
    .count(count), .tc_pulse(tc_pulse), .active(active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the counting rules, in plain integers
  task automatic model_update();
    int c, term, nxt;
    bit at_term;
    if (rst) begin
      m_count = 0; m_pcnt = 0; m_active = 1; m_tc = 0;
      return;
    end
    if (load) begin
      m_count = int'(load_value); m_pcnt = 0; m_active = 1; m_tc = 0;
      return;
    end
    m_tc = 0;
    if (!(enable && m_active != 0)) return;
    if (m_pcnt < int'(prescale)) begin
      m_pcnt++;
      return;
    end
    m_pcnt = 0;
    c    = m_count;
    term = direction ? int'(max_value) : 0;
    at_term = direction ? (c >= int'(max_value)) : (c == 0);
    if (!at_term) nxt = direction ? (c + 1) % 256 : (c + 255) % 256;
    else begin
      case (int'(mode))
        1:       nxt = term;
        2:       begin nxt = c; m_active = 0; end
        default: nxt = direction ? 0 : int'(max_value);
      endcase
    end
    m_tc = ((nxt == term) && !((mode == 2'b01 || mode == 2'b10) && c == term)) ? 1 : 0;
    m_count = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, int'(count), m_count);
    chk({tag, ".tc"}, int'(tc_pulse), m_tc);
    chk({tag, ".active"}, int'(active), m_active);
  endtask

  task automatic set_in(input bit ld, input int lv, input bit en, input bit dir,
                        input int mx, input int ps, input int md);
    load = ld; load_value = 8'(lv); enable = en; direction = dir;
    max_value = 8'(mx); prescale = 8'(ps); mode = 2'(md);
  endtask

  task automatic v(input bit ld, input int lv, input bit en, input bit dir, input int mx,
                   input int ps, input int md, input int ec, input bit et, input bit ea);
    vec_t r;
    r.ld = ld; r.lv = lv; r.en = en; r.dir = dir; r.mx = mx; r.ps = ps; r.md = md;
    r.ec = ec; r.et = et; r.ea = ea;
    vecs.push_back(r);
  endtask

  initial begin
    // wrap up, max 5
    for (int i = 1; i <= 5; i++) v(0, 0, 1, 1, 5, 0, 0, i, (i == 5), 1);
    v(0, 0, 1, 1, 5, 0, 0, 0, 0, 1);
    v(0, 0, 1, 1, 5, 0, 0, 1, 0, 1);
    v(0, 0, 0, 1, 5, 0, 0, 1, 0, 1);
    v(0, 0, 0, 1, 5, 0, 0, 1, 0, 1);
    // one-shot down from 3
    v(1, 3, 1, 0, 5, 0, 2, 3, 0, 1);
    v(0, 0, 1, 0, 5, 0, 2, 2, 0, 1);
    v(0, 0, 1, 0, 5, 0, 2, 1, 0, 1);
    v(0, 0, 1, 0, 5, 0, 2, 0, 1, 1);
    for (int i = 0; i < 11; i++) v(0, 0, 1, 0, 5, 0, 2, 0, 0, 0);
    v(1, 7, 1, 0, 5, 0, 2, 7, 0, 1);
    v(0, 0, 1, 0, 5, 0, 2, 6, 0, 1);
    // saturate with above-max load
    v(1, 12, 1, 1, 10, 0, 1, 12, 0, 1);
    v(0, 0, 1, 1, 10, 0, 1, 10, 1, 1);
    for (int i = 0; i < 3; i++) v(0, 0, 1, 1, 10, 0, 1, 10, 0, 1);
    // max_value 0 in wrap
    v(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) v(0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    // wrap down reloads max_value
    v(1, 1, 1, 0, 4, 0, 0, 1, 0, 1);
    v(0, 0, 1, 0, 4, 0, 0, 0, 1, 1);
    v(0, 0, 1, 0, 4, 0, 0, 4, 0, 1);
    v(0, 0, 1, 0, 4, 0, 0, 3, 0, 1);
    // reserved mode behaves as wrap
    v(1, 2, 1, 1, 3, 0, 3, 2, 0, 1);
    v(0, 0, 1, 1, 3, 0, 3, 3, 1, 1);
    v(0, 0, 1, 1, 3, 0, 3, 0, 0, 1);
    // load while disabled, then a direction change
    v(1, 50, 0, 1, 100, 0, 0, 50, 0, 1);
    v(0, 0, 1, 1, 100, 0, 0, 51, 0, 1);
    v(0, 0, 1, 0, 100, 0, 0, 50, 0, 1);

    rst = 1'b1;
    set_in(0, 0, 0, 1, 5, 0, 0);
    m_count = 0; m_pcnt = 0; m_active = 1; m_tc = 0;
    #1;
    chk("reset.count", int'(count), 0);
    chk("reset.tc", int'(tc_pulse), 0);
    chk("reset.active", int'(active), 1);
    #11;
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_in(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].dir, vecs[i].mx, vecs[i].ps, vecs[i].md);
      step();
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].ec);
      chk($sformatf("vec%0d.tc", i), int'(tc_pulse), int'(vecs[i].et));
      chk($sformatf("vec%0d.active", i), int'(active), int'(vecs[i].ea));
    end

    // prescale 2 with a 4-cycle enable gap mid-period
    set_in(1, 0, 1, 1, 200, 2, 0);
    step();
    for (int i = 1; i <= 12; i++) begin
      set_in(0, 0, !(i >= 5 && i <= 8), 1, 200, 2, 0);
      step();
      chk($sformatf("presc%0d.count", i), int'(count), (i >= 10) ? 2 : (i >= 3) ? 1 : 0);
    end

    // load on a tick cycle clears pcnt and suppresses the pulse
    set_in(1, 0, 1, 1, 10, 2, 0);
    step();
    set_in(0, 0, 1, 1, 10, 2, 0);
    step();
    step();
    set_in(1, 9, 1, 1, 10, 2, 0);
    step();
    chk("ldtick.count", int'(count), 9);
    chk("ldtick.tc", int'(tc_pulse), 0);
    set_in(0, 0, 1, 1, 10, 2, 0);
    step();
    step();
    chk("ldtick.hold", int'(count), 9);
    step();
    chk("ldtick.step", int'(count), 10);
    chk("ldtick.steptc", int'(tc_pulse), 1);

    // prescale shrunk below pcnt
    set_in(1, 0, 1, 1, 200, 5, 0);
    step();
    set_in(0, 0, 1, 1, 200, 5, 0);
    for (int i = 0; i < 4; i++) step();
    chk("pshrink.before", int'(count), 0);
    prescale = 8'd1;
    step();
    chk("pshrink.tick", int'(count), 1);
    step();
    step();
    chk("pshrink.period", int'(count), 2);

    // asynchronous reset mid-period
    set_in(0, 0, 1, 1, 200, 2, 0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("areset.count", int'(count), 0);
    chk("areset.tc", int'(tc_pulse), 0);
    chk("areset.active", int'(active), 1);
    step();
    rst = 1'b0;
    step();
    step();
    chk("areset.resume0", int'(count), 0);
    step();
    chk("areset.resume1", int'(count), 1);

    // randomized against the reference model
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        max_value = 8'($urandom_range(0, 12));
        mode      = 2'($urandom_range(0, 3));
        prescale  = 8'($urandom_range(0, 3));
        direction = 1'($urandom_range(0, 1));
      end
      load       = ($urandom_range(0, 24) == 0);
      load_value = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 15));
      enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) direction = ~direction;
      step();
      chk_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: count, load_value and max_value width.
REQ-002 SHALL have parameter PRESCALE_W, default 8: prescale width.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  allows prescaler advance and count steps.
REQ-006 SHALL have port load  input  1  synchronous load of load_value.
REQ-007 SHALL have port load_value  input  WIDTH  value taken on load.
REQ-008 SHALL have port direction  input  1  1 = up, 0 = down.
REQ-009 SHALL have port max_value  input  WIDTH  programmable terminal for up counting and reload value for down counting.
REQ-010 SHALL have port prescale  input  PRESCALE_W  one step per (prescale+1) enabled cycles.
REQ-011 SHALL have port mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port tc_pulse  output  1  registered one-cycle terminal-count pulse.
REQ-014 SHALL have port active  output  1  counter armed; 0 only after a one-shot completes.

Function
REQ-015 SHALL keep an internal prescaler counter pcnt of PRESCALE_W bits.
REQ-016 SHALL generate tick when enable=1, active=1, load=0 and pcnt==prescale.
- On tick: pcnt goes to 0.
- Otherwise, if enable=1 and active=1: pcnt increments.
- Otherwise: pcnt holds.
REQ-017 SHALL make prescale=0 produce a tick on every enabled, active cycle.
REQ-018 SHALL apply a prescale change on the cycle after it; if pcnt>prescale, pcnt SHALL return to 0 on the next enabled cycle, counted as a tick.
REQ-019 SHALL give load the highest priority: count<=load_value, pcnt<=0, active<=1, tc_pulse<=0, regardless of enable or mode; load_value SHALL NOT be clamped.
REQ-020 SHALL define the terminal per direction: up = count>=max_value; down = count==0.
REQ-021 SHALL, on tick when not at terminal, step count by exactly one: +1 up, -1 down, modulo 2^WIDTH arithmetic.
REQ-022 SHALL, on tick when at terminal, act per mode:
- wrap: up goes to 0; down goes to max_value.
- saturate: up goes to max_value (clamps if above); down holds 0.
- one-shot: count holds and active goes to 0.
REQ-023 SHALL assert tc_pulse in the cycle where a tick's resulting count equals the terminal value (up: max_value, down: 0).
- Exception: not when count already equalled that value before the tick in saturate or one-shot mode.
- tc_pulse SHALL be 0 in all other cycles.
REQ-024 SHALL, with max_value=0 in wrap mode, hold count at 0 and pulse tc_pulse on every tick.
REQ-025 SHALL sample direction, mode and max_value on each tick; a change affects the next step only, with no retroactive pulse.
REQ-026 SHALL freeze count, pcnt and outputs other than tc_pulse while active=0, until load.
REQ-027 SHALL hold count and pcnt when enable=0; tc_pulse SHALL be 0.

Reset
REQ-028 SHALL, on rst=1, immediately set count=0, pcnt=0, tc_pulse=0, active=1, independent of clk.
REQ-029 SHALL abort any operation when reset is asserted mid-count; after release, counting resumes from 0 with a full prescale period.
REQ-030 SHALL treat the first rising clk edge with rst=0 as a normal cycle.

Verification
REQ-031 SHALL cover wrap up: WIDTH=8, max_value=5, prescale=0, mode=00, direction=1, enable=1 -> count 0,1,2,3,4,5,0,1; tc_pulse high only with count=5.
REQ-032 SHALL cover prescale: prescale=2, up, wrap, max_value=200 -> count increments every 3rd enabled cycle; deasserting enable for 4 cycles mid-period stretches the period by exactly 4.
REQ-033 SHALL cover one-shot down: load_value=3, mode=10, direction=0, prescale=0 -> count 3,2,1,0; tc_pulse with 0; active=0 next; count stays 0 for 10 cycles; load re-arms.
REQ-034 SHALL cover saturate and above-max load: mode=01, up, max_value=10, load_value=12 -> next tick count=10 with tc_pulse; further ticks hold 10, no pulse.
REQ-035 SHALL cover load versus tick and reset: load asserted on a tick cycle -> count=load_value, pcnt=0, no pulse; async rst mid-period -> all outputs reset before the next clk edge.
